// File: rtl/sml_pkg.sv
// rtl/sml_pkg.sv - default widths and shared types for the match event logger
package sml_pkg;
  localparam int TS_W_DEF    = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int DEPTH_DEF   = 8;
  localparam int HOLDOFF_DEF = 4;
  localparam int PTR_W       = $clog2(DEPTH_DEF);

  typedef logic [TS_W_DEF-1:0] ts_t;
endpackage

// File: rtl/sml_ts_fifo.sv
// rtl/sml_ts_fifo.sv - synchronous first-word-fall-through FIFO with level counter
// The head is held in its own register so dout keeps its last value once the FIFO drains.
module sml_ts_fifo
  import sml_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]   level_q;
  logic [W-1:0]  head_q;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr_q + AW'(1);
  assign dout    = head_q;
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      // Head source: the next stored entry if one remains, otherwise the incoming word.
      if (do_pop && level_q > (AW+1)'(1))
        head_q <= mem_q[rd_nxt];
      else if (do_push && (empty || do_pop))
        head_q <= din;
    end
  end
endmodule

// File: rtl/seq_match_event_logger.sv
// rtl/seq_match_event_logger.sv - counts detector matches and queues their timestamps
// Optional post-event ignore window enabled by defining SML_HOLDOFF_EN.
module seq_match_event_logger
  import sml_pkg::*;
#(
  parameter int TS_W    = TS_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             detected_in,
  input  logic             enable,
  input  logic             clr,
  output logic             out_valid,
  output logic [TS_W-1:0]  out_ts,
  input  logic             out_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);
  logic [TS_W-1:0]  ts_q;
  logic [CNT_W-1:0] evt_count_q, evt_count_d;
  logic             overflow_q, overflow_d;
  logic             hold_idle, accept, full, empty;

  assign accept = detected_in & enable & ~clr & hold_idle;

`ifdef SML_HOLDOFF_EN
  localparam int HO_W = $clog2(HOLDOFF + 1);
  logic [HO_W-1:0] hold_q, hold_d;

  assign hold_idle = (hold_q == '0);

  always_comb begin
    hold_d = hold_q;
    if (clr)             hold_d = '0;
    else if (accept)     hold_d = HO_W'(HOLDOFF);
    else if (!hold_idle) hold_d = hold_q - HO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = ^HOLDOFF;
  assign hold_idle      = 1'b1;
`endif

  always_comb begin
    evt_count_d = evt_count_q;
    overflow_d  = overflow_q;
    if (clr) begin
      evt_count_d = '0;
      overflow_d  = 1'b0;
    end else if (accept) begin
      if (evt_count_q != '1) evt_count_d = evt_count_q + CNT_W'(1);
      // Full is only relieved by a same-cycle pop; full implies out_valid.
      if (full && !out_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q        <= '0;
      evt_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ts_q        <= ts_q + TS_W'(1);
      evt_count_q <= evt_count_d;
      overflow_q  <= overflow_d;
    end
  end

  sml_ts_fifo #(.W(TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (accept),
    .din   (ts_q),
    .pop   (out_ready),
    .dout  (out_ts),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign out_valid = ~empty;
  assign evt_count = evt_count_q;
  assign overflow  = overflow_q;
endmodule
